// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, one iteration per cycle, with flush abort and a registered result.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          op_r;
    logic [XLEN-1:0]     mag_r;
    logic [XLEN-1:0]     hi_r;
    logic [XLEN-1:0]     lo_r;
    logic [CW-1:0]       cnt_r;
    logic                neg_r;
    logic                a_neg_r;
    logic [XLEN-1:0]     result_r;

    logic                is_div_s;
    logic                sa_s;
    logic                sb_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                special_s;
    logic                ovf_s;
    logic [XLEN-1:0]     special_res_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       shifted_s;
    logic [XLEN-1:0]     hi_nxt_s;
    logic [XLEN-1:0]     lo_nxt_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     final_s;

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    // Decode the incoming op: operand signedness, magnitudes and the early-out cases.
    always_comb begin
        is_div_s = op_i[2];
        sa_s     = a_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_MULHSU) |
                                  (op_i == OP_DIV)  | (op_i == OP_REM));
        sb_s     = b_i[XLEN-1] & ((op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM));
        a_mag_s  = neg_if(sa_s, a_i);
        b_mag_s  = neg_if(sb_s, b_i);
        ovf_s    = ((op_i == OP_DIV) | (op_i == OP_REM)) & (a_i == MIN_NEG) &
                   (b_i == {XLEN{1'b1}});
        special_s = is_div_s & ((b_i == {XLEN{1'b0}}) | ovf_s);
        if (ovf_s) begin
            special_res_s = op_i[1] ? {XLEN{1'b0}} : MIN_NEG;
        end else if (op_i[1]) begin
            special_res_s = a_i;
        end else begin
            special_res_s = {XLEN{1'b1}};
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step on the latched state.
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(XLEN+1){1'b0}});
        shifted_s = {hi_r, lo_r[XLEN-1]};
        if (!op_r[2]) begin
            hi_nxt_s = sum_s[XLEN:1];
            lo_nxt_s = {sum_s[0], lo_r[XLEN-1:1]};
        end else if (shifted_s >= {1'b0, mag_r}) begin
            hi_nxt_s = shifted_s[XLEN-1:0] - mag_r;
            lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
        end else begin
            hi_nxt_s = shifted_s[XLEN-1:0];
            lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
        end
    end

    // Apply the sign fix-up and pick the result word after the last iteration.
    always_comb begin
        prod_s = neg_r ? -{hi_nxt_s, lo_nxt_s} : {hi_nxt_s, lo_nxt_s};
        case (op_r)
            OP_MUL:    final_s = prod_s[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  final_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV:    final_s = neg_if(neg_r, lo_nxt_s);
            OP_DIVU:   final_s = lo_nxt_s;
            OP_REM:    final_s = neg_if(a_neg_r, hi_nxt_s);
            OP_REMU:   final_s = hi_nxt_s;
            default:   final_s = {XLEN{1'b0}};
        endcase
    end

    // Sequencer: accept, iterate, deliver; flush aborts without touching the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            op_r     <= 3'd0;
            mag_r    <= {XLEN{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
            a_neg_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else if (flush_i) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        op_r    <= op_i;
                        mag_r   <= is_div_s ? b_mag_s : a_mag_s;
                        lo_r    <= is_div_s ? a_mag_s : b_mag_s;
                        hi_r    <= {XLEN{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        neg_r   <= sa_s ^ sb_s;
                        a_neg_r <= sa_s;
                        if (special_s) begin
                            result_r <= special_res_s;
                            state_r  <= S_DONE;
                        end else begin
                            state_r  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    hi_r  <= hi_nxt_s;
                    lo_r  <= lo_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(XLEN-1)) begin
                        result_r <= final_s;
                        state_r  <= S_DONE;
                    end
                end
                S_DONE:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_r == S_BUSY);
    assign done_o   = (state_r == S_DONE);
    assign result_o = result_r;
    assign stall_o  = start_i & ~done_o & ~flush_i & ~rst;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq: results, latency, stall/busy,
// flush abort, operand latching, back-to-back issue and reset mid-op.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        stall_o;

    int checks   = 0;
    int failures = 0;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .stall_o  (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current cycle (cycle 0) and follow it to done_o.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit toggle, input bit keep_start);
        int lat;
        bit stall_ok;
        bit busy_ok;
        lat = -1;
        stall_ok = 1'b1;
        busy_ok = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done_o) begin
                lat = c;
                if (stall_o) stall_ok = 1'b0;
                break;
            end
            if (!stall_o) stall_ok = 1'b0;
            if (busy_o !== (c > 0)) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (toggle) begin
                a_i = $urandom;
                b_i = $urandom;
                op_i = 3'($urandom);
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        if (!keep_start) start_i = 1'b0;
    endtask

    initial begin
        bit no_done;
        rst = 1'b1;
        flush_i = 1'b0;
        start_i = 1'b1;
        op_i = 3'd0;
        a_i = 32'd3;
        b_i = 32'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;

        do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);
        do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0);
        do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0, 1'b0);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, 1'b0);
        do_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0, 1'b0);
        do_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0, 1'b0);
        do_op("divu",   3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, 1'b0, 1'b0);
        do_op("remu",   3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001, 33, 1'b0, 1'b0);
        do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, 1'b0);
        do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0, 1'b0);
        do_op("divu_z", 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0, 1'b0);
        do_op("remu_z", 3'd7, 32'd5,        32'd0,        32'h00000005, 1,  1'b0, 1'b0);

        // Flush at cycle 10 of DIV 100/7; result must stay at 5 from REMU.
        op_i = 3'd4;
        a_i = 32'd100;
        b_i = 32'd7;
        start_i = 1'b1;
        no_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_o) no_done = 1'b0;
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        check("flush_busy_c10", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("flush_busy_c11", {31'd0, busy_o}, 32'd0);
        check("flush_done_c11", {31'd0, done_o}, 32'd0);
        check("flush_nodone", {31'd0, no_done}, 32'd1);
        check("flush_result", result_o, 32'd5);
        @(posedge clk); #1;
        do_op("div_after_flush", 3'd4, 32'd100, 32'd7, 32'd14, 33, 1'b0, 1'b0);

        // Operands wiggle during BUSY, then a back-to-back op the cycle after DONE.
        do_op("divu_toggle", 3'd5, 32'h12345678, 32'h00001234, 32'h00010004, 33, 1'b1, 1'b1);
        do_op("remu_b2b",    3'd7, 32'h12345678, 32'h00001234, 32'h00000DA8, 33, 1'b0, 1'b0);

        // Reset mid-op clears the result.
        op_i = 3'd3;
        a_i = 32'hFFFFFFFF;
        b_i = 32'hFFFFFFFF;
        start_i = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_done", {31'd0, done_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
